// File: rtl/i2c_init_seq.sv
// Init-table walker for the I2C register-init path: decodes write/delay/end
// entries, feeds the write engine over valid/ready and retries NACKed writes.
module i2c_init_seq #(
    parameter int unsigned ROM_DEPTH      = 65,
    parameter int unsigned ADDR_W         = 7,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned STROBES_PER_MS = 100
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              strobe_100kHz,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [15:0]       wr_data,
    input  logic              wr_done,
    input  logic              wr_nack,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_index
);
    localparam int unsigned       RETRY_W  = $clog2(MAX_RETRY + 2);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ROM_DEPTH - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_SEND, S_WAIT,
        S_DELAY, S_ADVANCE, S_DONE, S_ERROR
    } state_t;

    state_t             state;
    logic [RETRY_W-1:0] retry;
    logic [15:0]        delay_cnt;
    logic [15:0]        delay_target;

    // rom_addr doubles as the walk index; it only moves in FETCH-bound transitions
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state        <= S_IDLE;
            rom_addr     <= '0;
            wr_valid     <= 1'b0;
            wr_data      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_index    <= '0;
            retry        <= '0;
            delay_cnt    <= '0;
            delay_target <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state     <= S_FETCH;
                        rom_addr  <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        err_index <= '0;
                        retry     <= '0;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    if (rom_data == 16'hFFFF) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (rom_data[15:8] == 8'hFE) begin
                        state        <= S_DELAY;
                        delay_cnt    <= '0;
                        delay_target <= 16'(rom_data[7:0]) * 16'(STROBES_PER_MS);
                    end else begin
                        state    <= S_SEND;
                        wr_data  <= rom_data;
                        wr_valid <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (wr_ready) begin
                        wr_valid <= 1'b0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wr_done) begin
                        if (!wr_nack) begin
                            retry <= '0;
                            state <= S_ADVANCE;
                        end else if (retry < RETRY_W'(MAX_RETRY)) begin
                            retry    <= retry + 1'b1;
                            wr_valid <= 1'b1;
                            state    <= S_SEND;
                        end else begin
                            state     <= S_ERROR;
                            busy      <= 1'b0;
                            error     <= 1'b1;
                            err_index <= rom_addr;
                        end
                    end
                end
                S_DELAY: begin
                    if (delay_target == 16'd0) begin
                        state <= S_ADVANCE;
                    end else if (strobe_100kHz) begin
                        if (delay_cnt == delay_target - 16'd1) state <= S_ADVANCE;
                        else delay_cnt <= delay_cnt + 16'd1;
                    end
                end
                S_ADVANCE: begin
                    if (rom_addr == LAST_IDX) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        rom_addr <= rom_addr + 1'b1;
                        state    <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_init_seq.sv
// Self-checking bench for i2c_init_seq: synchronous ROM model, behavioural
// write engine with stall/NACK policy, and a scoreboard of expected transfers.
module tb_i2c_init_seq;
    localparam int unsigned ADDR_W = 7;

    logic              clk = 1'b0;
    logic              areset_n = 1'b0;
    logic              strobe_100kHz = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data = '0;
    logic              wr_valid;
    logic              wr_ready;
    logic [15:0]       wr_data;
    logic              wr_done;
    logic              wr_nack;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] err_index;

    logic [15:0] rom [128];
    logic [15:0] tbl [$];
    logic [15:0] sb  [$];

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned stall_clks = 0;
    int unsigned nack_limit = 0;
    int unsigned nack_seen = 0;
    logic [15:0] nack_data = '0;

    i2c_init_seq #(
        .ROM_DEPTH(65), .ADDR_W(ADDR_W), .MAX_RETRY(3), .STROBES_PER_MS(100)
    ) dut (
        .clk(clk), .areset_n(areset_n), .strobe_100kHz(strobe_100kHz), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_done(wr_done), .wr_nack(wr_nack), .busy(busy), .done(done),
        .error(error), .err_index(err_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_table();
        for (int i = 0; i < 128; i++) rom[i] = (i < tbl.size()) ? tbl[i] : 16'hFFFF;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int unsigned budget);
        int unsigned n = 0;
        while (!(done || error) && n < budget) begin
            @(negedge clk);
            strobe_100kHz = ((n % 4) == 3);
            n++;
        end
        strobe_100kHz = 1'b0;
        chk("end_reached", 32'(done | error), 1);
    endtask

    task automatic wait_valid(input int unsigned budget);
        int unsigned n = 0;
        while (!wr_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("valid_seen", 32'(wr_valid), 1);
    endtask

    // Write engine: ready after stall_clks, done two clocks after the transfer
    initial begin
        logic        hs_pend;
        logic        latched;
        logic        pend_nack;
        logic [15:0] lat;
        int unsigned stall_cnt;
        int unsigned pend_done;
        wr_ready = 1'b0; wr_done = 1'b0; wr_nack = 1'b0;
        hs_pend = 1'b0; latched = 1'b0; pend_nack = 1'b0; lat = '0;
        stall_cnt = 0; pend_done = 0;
        forever begin
            @(negedge clk);
            wr_done = 1'b0;
            wr_nack = 1'b0;
            if (!areset_n) begin
                wr_ready = 1'b0; hs_pend = 1'b0; latched = 1'b0;
                stall_cnt = 0; pend_done = 0;
                continue;
            end
            if (pend_done > 0) begin
                pend_done--;
                if (pend_done == 0) begin
                    wr_done = 1'b1;
                    wr_nack = pend_nack;
                end
            end
            if (hs_pend) begin
                wr_ready = 1'b0; hs_pend = 1'b0; latched = 1'b0;
                chk("valid_drop", 32'(wr_valid), 0);
                chk("xfer_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) chk("xfer_data", 32'(lat), 32'(sb.pop_front()));
                pend_nack = (lat == nack_data) && (nack_seen < nack_limit);
                if (pend_nack) nack_seen++;
                pend_done = 2;
            end else if (wr_valid) begin
                if (!latched) begin
                    latched = 1'b1; lat = wr_data; stall_cnt = 0;
                end else if (stall_clks > 0) begin
                    chk("stall_data", 32'(wr_data), 32'(lat));
                end
                if (stall_cnt >= stall_clks) begin
                    wr_ready = 1'b1; hs_pend = 1'b1;
                end else begin
                    stall_cnt++;
                end
            end else if (latched) begin
                chk("valid_held", 32'(wr_valid), 1);
                latched = 1'b0;
            end
        end
    end

    initial begin
        int unsigned n;
        int unsigned cnt;
        for (int i = 0; i < 128; i++) rom[i] = 16'hFFFF;
        repeat (3) @(negedge clk);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_wr_valid", 32'(wr_valid), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_err_index", 32'(err_index), 0);
        areset_n = 1'b1;

        // two writes then END, with start-to-valid latency
        tbl = '{16'h1234, 16'h5678, 16'hFFFF};
        load_table();
        sb.push_back(16'h1234); sb.push_back(16'h5678);
        do_start();
        chk("t1_fetch_valid", 32'(wr_valid), 0);
        chk("t1_fetch_busy", 32'(busy), 1);
        @(negedge clk);
        chk("t1_decode_valid", 32'(wr_valid), 0);
        @(negedge clk);
        chk("t1_send_valid", 32'(wr_valid), 1);
        chk("t1_send_data", 32'(wr_data), 32'h1234);
        wait_end(200);
        chk("t1_done", 32'(done), 1);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_error", 32'(error), 0);
        repeat (5) @(negedge clk);
        chk("t1_no_extra", 32'(wr_valid), 0);
        chk("t1_sb_empty", 32'(sb.size()), 0);

        // 2 ms delay: strobes counted from DELAY entry until the write appears
        tbl = '{16'hFE02, 16'h0A0B, 16'hFFFF};
        load_table();
        sb.push_back(16'h0A0B);
        do_start();
        n = 0; cnt = 0;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (wr_valid) break;
            strobe_100kHz = (n >= 2) && (((n - 2) % 4) == 0);
            if (strobe_100kHz) cnt++;
        end
        strobe_100kHz = 1'b0;
        chk("t2_delay_window", 32'(cnt >= 199 && cnt <= 201), 1);
        chk("t2_data", 32'(wr_data), 32'h0A0B);
        wait_end(200);
        chk("t2_done", 32'(done), 1);
        chk("t2_sb_empty", 32'(sb.size()), 0);

        // two NACKs then ACK; walk continues
        tbl = '{16'h1111, 16'h3333, 16'hFFFF};
        load_table();
        nack_data = 16'h1111; nack_limit = 2; nack_seen = 0;
        repeat (3) sb.push_back(16'h1111);
        sb.push_back(16'h3333);
        do_start();
        wait_end(400);
        chk("t3_done", 32'(done), 1);
        chk("t3_error", 32'(error), 0);
        chk("t3_sb_empty", 32'(sb.size()), 0);

        // persistent NACK at index 4 exhausts retries
        tbl = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h2222, 16'hFFFF};
        load_table();
        nack_data = 16'h2222; nack_limit = 1000; nack_seen = 0;
        sb.push_back(16'h0101); sb.push_back(16'h0202);
        sb.push_back(16'h0303); sb.push_back(16'h0404);
        repeat (4) sb.push_back(16'h2222);
        do_start();
        wait_end(600);
        chk("t4_error", 32'(error), 1);
        chk("t4_done", 32'(done), 0);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_err_index", 32'(err_index), 4);
        chk("t4_sb_empty", 32'(sb.size()), 0);
        nack_limit = 0; nack_seen = 0;
        sb.push_back(16'h0101); sb.push_back(16'h0202);
        sb.push_back(16'h0303); sb.push_back(16'h0404);
        sb.push_back(16'h2222);
        do_start();
        chk("t4r_error_clr", 32'(error), 0);
        chk("t4r_err_index_clr", 32'(err_index), 0);
        chk("t4r_rom_addr", 32'(rom_addr), 0);
        wait_end(600);
        chk("t4r_done", 32'(done), 1);
        chk("t4r_sb_empty", 32'(sb.size()), 0);

        // 65 writes, no END, 10-clock stall per request
        tbl.delete();
        for (int i = 0; i < 65; i++) begin
            tbl.push_back(16'h1000 + 16'(i));
            sb.push_back(16'h1000 + 16'(i));
        end
        load_table();
        stall_clks = 10;
        do_start();
        wait_end(3000);
        chk("t5_done", 32'(done), 1);
        chk("t5_error", 32'(error), 0);
        chk("t5_last_index", 32'(rom_addr), 64);
        chk("t5_sb_empty", 32'(sb.size()), 0);

        // reset while stalled in SEND, then restart
        tbl = '{16'h1234, 16'hFFFF};
        load_table();
        stall_clks = 50;
        sb.push_back(16'h1234);
        do_start();
        wait_valid(20);
        @(negedge clk);
        areset_n = 1'b0;
        #1;
        chk("t6_send_rst_valid", 32'(wr_valid), 0);
        chk("t6_send_rst_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        sb.delete();
        areset_n = 1'b1;
        stall_clks = 0;
        sb.push_back(16'h1234);
        do_start();
        chk("t6_restart_addr", 32'(rom_addr), 0);
        wait_end(200);
        chk("t6_restart_done", 32'(done), 1);
        chk("t6_sb_empty", 32'(sb.size()), 0);

        // reset during DELAY, then restart through the delay
        tbl = '{16'hFE01, 16'h0A0B, 16'hFFFF};
        load_table();
        do_start();
        repeat (4) @(negedge clk);
        chk("t6_delay_busy", 32'(busy), 1);
        areset_n = 1'b0;
        #1;
        chk("t6_delay_rst_busy", 32'(busy), 0);
        chk("t6_delay_rst_valid", 32'(wr_valid), 0);
        repeat (2) @(negedge clk);
        areset_n = 1'b1;
        sb.push_back(16'h0A0B);
        do_start();
        wait_end(1000);
        chk("t6d_done", 32'(done), 1);
        chk("t6d_sb_empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
